// File: rtl/mux16_rr_arbiter.sv
// rtl/mux16_rr_arbiter.sv - round-robin grant and select control for the mux16 16:1 mux
// Optional lock input that suppresses tenure timeout: define MUX16_ARB_LOCK_EN.
module mux16_rr_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        done,
`ifdef MUX16_ARB_LOCK_EN
  input  logic        lock,
`endif
  output logic [15:0] gnt,
  output logic [3:0]  sel,
  output logic        valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  state_t            state, state_nxt;
  logic [15:0]       gnt_nxt;
  logic [3:0]        sel_nxt, ptr, ptr_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              valid_nxt;
  logic              hold_lock, timeout, dropped, release_ev;
  logic [15:0]       elig;
  logic [4:0]        win;

  // Returns {found, index} of the first set bit of v scanning p, p+1, ... circularly.
  function automatic logic [4:0] pick(input logic [15:0] v, input logic [3:0] p);
    logic [4:0] r;
    logic [3:0] k;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      k = p + 4'(i);
      if (v[k]) r = {1'b1, k};
    end
    return r;
  endfunction

`ifdef MUX16_ARB_LOCK_EN
  assign hold_lock = lock;
`else
  assign hold_lock = 1'b0;
`endif

  // >= rather than == so that a count that ran past the limit under lock times out once lock drops.
  assign timeout    = (HOLD_MAX != 0) && (cnt >= CNT_LAST) && !hold_lock;
  assign dropped    = !req[sel];
  assign release_ev = done || dropped || timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= 16'h0000;
      sel   <= 4'h0;
      valid <= 1'b0;
      ptr   <= 4'h0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      sel   <= sel_nxt;
      valid <= valid_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    sel_nxt   = sel;
    valid_nxt = valid;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    elig      = req;
    win       = '0;
    case (state)
      IDLE: begin
        win = pick(req, ptr);
      end
      GRANT: begin
        if (release_ev) begin
          ptr_nxt = sel + 4'd1;
          // A timed-out owner stays eligible; it only loses priority.
          if (done || dropped) elig[sel] = 1'b0;
          win = pick(elig, sel + 4'd1);
          if (!win[4]) begin
            state_nxt = IDLE;
            gnt_nxt   = 16'h0000;
            valid_nxt = 1'b0;
          end
        end else if (cnt != CNT_SAT) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (win[4]) begin
      state_nxt = GRANT;
      gnt_nxt   = 16'h0001 << win[3:0];
      sel_nxt   = win[3:0];
      valid_nxt = 1'b1;
      cnt_nxt   = '0;
    end
  end

endmodule
